search_scheduler: RTL and testbench

Sequences the brute-force candidate search on the Nexys4DDR build. It partitions the 32-bit candidate space into fixed-size chunks and dispatches them round-robin to LANES independent counter/hash lanes. It collects lane completions and hits, latches the first found candidate, and drives the five board status LEDs. It sits between the board-level `driver` inputs (enable, target) and the lane array.

---
 rtl/search_scheduler_if.sv | 21 ++
 rtl/search_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_search_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/search_scheduler_if.sv
// Lane-array bus between the search scheduler (master) and the worker lanes (slave).
interface search_scheduler_if #(
  parameter int unsigned LANES = 8
);
  logic [LANES-1:0]    lane_start;
  logic [31:0]         lane_base;
  logic                lane_abort;
  logic [LANES-1:0]    lane_busy;
  logic [LANES-1:0]    lane_found;
  logic [32*LANES-1:0] lane_found_value;

  modport master (
    output lane_start, lane_base, lane_abort,
    input  lane_busy, lane_found, lane_found_value
  );

  modport slave (
    input  lane_start, lane_base, lane_abort,
    output lane_busy, lane_found, lane_found_value
  );
endinterface

// File: rtl/search_scheduler.sv
// Splits the 32-bit candidate space into chunks, dispatches them round-robin to
// the lane array, latches the first hit and drives the board status LEDs.
module search_scheduler #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned CHUNK_BITS = 12,
  parameter int unsigned WARMUP     = 64
) (
  input  logic                     CLK,
  input  logic                     CPU_RESETN,
  input  logic                     start,
  input  logic                     enable,
  input  logic [31:0]              target,
  search_scheduler_if.master       lanes,
  output logic [31:0]              result,
  output logic                     result_valid,
  output logic                     status_paused,
  output logic                     status_running,
  output logic                     status_warming,
  output logic                     status_found,
  output logic                     status_done
);

  localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CW = $clog2(WARMUP + 1);
  localparam logic [32:0] CHUNK = 33'(1) << CHUNK_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WARM, S_RUN, S_PAUSE, S_DRAIN, S_FOUND, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        target_q, target_d;
  logic [32:0]        next_base_q, next_base_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [LANES-1:0]   pending_q, pending_d;
  logic [LANES-1:0]   lane_start_q, lane_start_d;
  logic [31:0]        lane_base_q, lane_base_d;
  logic               lane_abort_q, lane_abort_d;
  logic [31:0]        result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [4:0]         status_q, status_d;

  logic [31:0]        hit_value;
  logic [LANES-1:0]   eligible, ge_mask, cand;
  logic [PW-1:0]      pick;
  logic               exhausted, take_hit;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    next_base_d    = next_base_q;
    ptr_d          = ptr_q;
    pending_d      = '0;
    lane_start_d   = '0;
    lane_base_d    = lane_base_q;
    lane_abort_d   = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    hit_value      = '0;
    ge_mask        = '0;
    pick           = '0;

    // Lowest-index hit wins: scan downward so the last match is the lowest lane.
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (lanes.lane_found[i]) hit_value = lanes.lane_found_value[32*i +: 32];
    end

    // Round-robin pick: prefer eligible lanes at/after the pointer, else wrap.
    eligible = ~lanes.lane_busy & ~pending_q;
    for (int i = 0; i < int'(LANES); i++) ge_mask[i] = (PW'(i) >= ptr_q);
    cand = (|(eligible & ge_mask)) ? (eligible & ge_mask) : eligible;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (cand[i]) pick = PW'(i);
    end

    exhausted = next_base_q[32] || (next_base_q > {1'b0, target_q});
    take_hit  = (|lanes.lane_found) &&
                !(state_q inside {S_IDLE, S_FOUND, S_DONE});

    case (state_q)
      S_IDLE, S_FOUND, S_DONE: begin
        if (start) begin
          state_d        = S_WARM;
          cnt_d          = CW'(WARMUP);
          target_d       = target;
          next_base_d    = '0;
          ptr_d          = '0;
          result_d       = '0;
          result_valid_d = 1'b0;
        end
      end
      S_WARM: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = enable ? S_RUN : S_PAUSE;
      end
      S_RUN: begin
        if (exhausted) begin
          state_d = S_DRAIN;
        end else if (!enable) begin
          state_d = S_PAUSE;
        end else if (|eligible) begin
          lane_start_d = LANES'(1) << pick;
          pending_d    = LANES'(1) << pick;
          lane_base_d  = next_base_q[31:0];
          next_base_d  = next_base_q + CHUNK;
          ptr_d        = (32'(pick) == LANES - 1) ? '0 : pick + PW'(1);
        end
      end
      S_PAUSE: begin
        if (enable) state_d = S_RUN;
      end
      S_DRAIN: begin
        if (lanes.lane_busy == '0 && pending_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A hit overrides any dispatch or exhaustion decision made this cycle.
    if (take_hit) begin
      state_d        = S_FOUND;
      result_d       = hit_value;
      result_valid_d = 1'b1;
      lane_abort_d   = 1'b1;
      lane_start_d   = '0;
      pending_d      = '0;
      lane_base_d    = lane_base_q;
      next_base_d    = next_base_q;
      ptr_d          = ptr_q;
    end

    // {paused, running, warming, found, done}; draining still shows as running.
    case (state_d)
      S_PAUSE:          status_d = 5'b10000;
      S_RUN, S_DRAIN:   status_d = 5'b01000;
      S_WARM:           status_d = 5'b00100;
      S_FOUND:          status_d = 5'b00010;
      S_DONE:           status_d = 5'b00001;
      default:          status_d = 5'b00000;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      target_q       <= '0;
      next_base_q    <= '0;
      ptr_q          <= '0;
      pending_q      <= '0;
      lane_start_q   <= '0;
      lane_base_q    <= '0;
      lane_abort_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      status_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      next_base_q    <= next_base_d;
      ptr_q          <= ptr_d;
      pending_q      <= pending_d;
      lane_start_q   <= lane_start_d;
      lane_base_q    <= lane_base_d;
      lane_abort_q   <= lane_abort_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      status_q       <= status_d;
    end
  end

  assign lanes.lane_start = lane_start_q;
  assign lanes.lane_base  = lane_base_q;
  assign lanes.lane_abort = lane_abort_q;
  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign status_paused    = status_q[4];
  assign status_running   = status_q[3];
  assign status_warming   = status_q[2];
  assign status_found     = status_q[1];
  assign status_done      = status_q[0];

endmodule

// File: tb/tb_search_scheduler.sv
// Directed bench for search_scheduler: an 8-lane instance plus a 1-lane,
// WARMUP=1, 2^28-chunk instance for the single-dispatch and wrap cases.
module tb_search_scheduler;

  localparam int unsigned WU = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        CPU_RESETN, start, enable;
  logic [31:0] target, result;
  logic        result_valid, status_paused, status_running, status_warming, status_found, status_done;
  logic        start1, enable1;
  logic [31:0] target1, result1;
  logic        result_valid1, status_paused1, status_running1, status_warming1, status_found1, status_done1;

  search_scheduler_if #(.LANES(8)) lif ();
  search_scheduler_if #(.LANES(1)) lif1 ();

  search_scheduler #(.LANES(8), .CHUNK_BITS(12), .WARMUP(WU)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .start(start), .enable(enable), .target(target),
    .lanes(lif), .result(result), .result_valid(result_valid),
    .status_paused(status_paused), .status_running(status_running),
    .status_warming(status_warming), .status_found(status_found), .status_done(status_done)
  );

  search_scheduler #(.LANES(1), .CHUNK_BITS(28), .WARMUP(1)) dut1 (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN), .start(start1), .enable(enable1), .target(target1),
    .lanes(lif1), .result(result1), .result_valid(result_valid1),
    .status_paused(status_paused1), .status_running(status_running1),
    .status_warming(status_warming1), .status_found(status_found1), .status_done(status_done1)
  );

  // Lane models: busy for busy_len cycles starting the cycle after lane_start.
  int busy_len = 20;
  int bcnt [8];
  int bcnt1;
  always @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 8; i++) bcnt[i] <= 0;
      bcnt1 <= 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (lif.lane_abort)         bcnt[i] <= 0;
        else if (lif.lane_start[i]) bcnt[i] <= busy_len;
        else if (bcnt[i] > 0)       bcnt[i] <= bcnt[i] - 1;
      end
      if (lif1.lane_abort)         bcnt1 <= 0;
      else if (lif1.lane_start[0]) bcnt1 <= 3;
      else if (bcnt1 > 0)          bcnt1 <= bcnt1 - 1;
    end
  end
  always_comb begin
    for (int i = 0; i < 8; i++) lif.lane_busy[i] = (bcnt[i] != 0);
    lif1.lane_busy[0] = (bcnt1 != 0);
  end

  // Dispatch logs sampled just after each rising edge.
  int          cyc = 0;
  int          bad1h = 0;
  logic [31:0] lb [$];
  int          ll [$];
  int          lc [$];
  logic [31:0] lb1 [$];
  int          lc1 [$];
  always @(posedge CLK) begin
    int idx;
    cyc++;
    #1;
    if (lif.lane_start != 8'h00) begin
      if (!$onehot(lif.lane_start)) bad1h++;
      idx = 0;
      for (int i = 0; i < 8; i++) if (lif.lane_start[i]) idx = i;
      lb.push_back(lif.lane_base);
      ll.push_back(idx);
      lc.push_back(cyc);
    end
    if (lif1.lane_start[0]) begin
      lb1.push_back(lif1.lane_base);
      lc1.push_back(cyc);
    end
  end

  int cmp_n = 0;
  int err_n = 0;
  int s_cyc, s_cyc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    lb.delete(); ll.delete(); lc.delete();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic pulse_start1();
    lb1.delete(); lc1.delete();
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    s_cyc1 = cyc;
  endtask

  task automatic wait_disp(input int n, input int lim, input string tag);
    int k = 0;
    while (lb.size() < n && k < lim) begin @(negedge CLK); k++; end
    chk(tag, 64'(lb.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int lim, input string tag);
    int k = 0;
    while (!status_done && k < lim) begin @(negedge CLK); k++; end
    chk(tag, 64'(status_done), 64'd1);
  endtask

  task automatic wait_done1(input int lim, input string tag);
    int k = 0;
    while (!status_done1 && k < lim) begin @(negedge CLK); k++; end
    chk(tag, 64'(status_done1), 64'd1);
  endtask

  task automatic chk_order(input string tag);
    int bad = 0;
    for (int i = 0; i < lb.size(); i++)
      if (lb[i] !== 32'(i) * 32'h1000 || ll[i] != i % 8) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic count_warm(input string tag);
    int w = 0;
    while (status_warming && w < 100) begin w++; @(negedge CLK); end
    chk(tag, 64'(w), 64'(WU));
  endtask

  initial begin
    int n0, pc, bad, zc;
    CPU_RESETN = 1'b0; start = 1'b0; enable = 1'b1; target = '0;
    start1 = 1'b0; enable1 = 1'b1; target1 = '0;
    lif.lane_found = '0;  lif.lane_found_value = '0;
    lif1.lane_found = '0; lif1.lane_found_value = '0;
    repeat (3) @(negedge CLK);
    chk("reset_status", 64'({status_paused, status_running, status_warming, status_found, status_done}), 64'd0);
    chk("reset_lane", 64'({lif.lane_start, lif.lane_abort, lif.lane_base}), 64'd0);
    chk("reset_result", 64'({result_valid, result}), 64'd0);
    CPU_RESETN = 1'b1;
    @(negedge CLK);
    chk("idle_status", 64'({status_paused, status_running, status_warming, status_found, status_done}), 64'd0);

    // Full sweep of 8 chunks, no hits
    target = 32'h7000; busy_len = 20;
    pulse_start();
    count_warm("A_warm_cycles");
    chk("A_running", 64'(status_running), 64'd1);
    wait_done(200, "A_done");
    chk("A_count", 64'(lb.size()), 64'd8);
    if (lb.size() > 0) chk("A_first_latency", 64'(lc[0] - s_cyc), 64'(WU + 1));
    chk_order("A_order");
    bad = 0;
    for (int i = 1; i < lc.size(); i++) if (lc[i] != lc[i-1] + 1) bad++;
    chk("A_one_per_cycle", 64'(bad), 64'd0);
    chk("A_no_result", 64'(result_valid), 64'd0);

    // Simultaneous hits from lanes 5 and 2 while dispatch is eligible
    target = 32'h7FFF_F000; busy_len = 6;
    pulse_start();
    wait_disp(12, 200, "C_dispatching");
    lif.lane_found = 8'b0010_0100;
    lif.lane_found_value[5*32 +: 32] = 32'h0000_1234;
    lif.lane_found_value[2*32 +: 32] = 32'h0000_0ABC;
    @(negedge CLK);
    lif.lane_found = '0;
    n0 = lb.size();
    chk("C_result", 64'(result), 64'h0ABC);
    chk("C_valid", 64'(result_valid), 64'd1);
    chk("C_abort", 64'(lif.lane_abort), 64'd1);
    chk("C_found", 64'(status_found), 64'd1);
    chk("C_hit_beats_dispatch", 64'(lif.lane_start), 64'd0);
    @(negedge CLK);
    chk("C_abort_one_cycle", 64'(lif.lane_abort), 64'd0);
    repeat (20) @(negedge CLK);
    chk("C_no_more_starts", 64'(lb.size()), 64'(n0));
    chk("C_found_hold", 64'({status_found, result}), {31'd0, 1'b1, 32'h0ABC});

    // Pause for 50 cycles, resume, then hit during a second pause
    pulse_start();
    wait_disp(10, 200, "D_dispatching");
    enable = 1'b0;
    n0 = lb.size();
    pc = 0;
    repeat (50) begin @(negedge CLK); if (status_paused) pc++; end
    chk("D_paused_cycles", 64'(pc), 64'd50);
    chk("D_no_starts_paused", 64'(lb.size()), 64'(n0));
    enable = 1'b1;
    wait_disp(n0 + 10, 100, "D_resumed");
    if (lb.size() > n0) chk("D_resume_base", 64'(lb[n0]), 64'(32'(n0) * 32'h1000));
    chk_order("D_order");
    enable = 1'b0;
    repeat (3) @(negedge CLK);
    lif.lane_found = 8'b0000_1000;
    lif.lane_found_value[3*32 +: 32] = 32'hDEAD_BEEF;
    @(negedge CLK);
    lif.lane_found = '0;
    enable = 1'b1;
    chk("D_pause_hit_result", 64'({result_valid, result}), {31'd0, 1'b1, 32'hDEAD_BEEF});
    chk("D_pause_hit_status", 64'({status_paused, status_found}), 64'b01);

    // start during RUN is ignored
    pulse_start();
    wait_disp(5, 200, "E_dispatching");
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("E_still_running", 64'({status_warming, status_running}), 64'b01);
    wait_disp(14, 100, "E_continues");
    chk_order("E_order");

    // Asynchronous reset mid-RUN, then a fresh start
    #2 CPU_RESETN = 1'b0;
    #1;
    chk("F_async_status", 64'({status_paused, status_running, status_warming, status_found, status_done}), 64'd0);
    chk("F_async_lane", 64'({lif.lane_start, lif.lane_abort, lif.lane_base}), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    CPU_RESETN = 1'b1;
    @(negedge CLK);
    pulse_start();
    count_warm("F_warm_cycles");
    wait_disp(1, 20, "F_dispatch");
    if (lb.size() > 0) begin
      chk("F_first_base", 64'(lb[0]), 64'd0);
      chk("F_first_latency", 64'(lc[0] - s_cyc), 64'(WU + 1));
    end

    // Single lane, WARMUP=1, target=0
    target1 = 32'h0;
    pulse_start1();
    wait_done1(50, "G_done");
    chk("G_count", 64'(lb1.size()), 64'd1);
    if (lb1.size() > 0) begin
      chk("G_base", 64'(lb1[0]), 64'd0);
      chk("G_latency", 64'(lc1[0] - s_cyc1), 64'd2);
    end

    // Base wraps past 0xFFFFFFFF; 2^28-sized chunks keep the run short
    target1 = 32'hFFFF_F000;
    pulse_start1();
    wait_done1(400, "H_done");
    chk("H_count", 64'(lb1.size()), 64'd16);
    if (lb1.size() == 16) chk("H_last_base", 64'(lb1[15]), 64'hF000_0000);
    zc = 0; bad = 0;
    for (int i = 0; i < lb1.size(); i++) begin
      if (lb1[i] == 32'h0) zc++;
      if (lb1[i] !== 32'(i) << 28) bad++;
    end
    chk("H_zero_once", 64'(zc), 64'd1);
    chk("H_order", 64'(bad), 64'd0);

    chk("onehot_lane_start", 64'(bad1h), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
